// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - hazard controller pipeline-side signal bundle
//
// Groups every hazard-controller signal except clk/rst.
//   master : pipeline side (drives ID/EX/MEM status and dmem_ack, receives controls)
//   slave  : hazard controller (receives status, drives controls, dmem_req, stall_cnt)
interface pipeline_hazard_ctrl_if #(
    parameter int REG_NUM_WIDTH = 5,
    parameter int CNT_WIDTH     = 32
);
    logic                     id_valid;
    logic [REG_NUM_WIDTH-1:0] id_rs;
    logic [REG_NUM_WIDTH-1:0] id_rt;
    logic                     id_use_rs;
    logic                     id_use_rt;
    logic                     ex_valid;
    logic                     ex_is_load;
    logic                     ex_rf_wr;
    logic [REG_NUM_WIDTH-1:0] ex_dst;
    logic                     ex_br_taken;
    logic                     mem_valid;
    logic                     mem_is_access;
    logic                     dmem_ack;
    logic                     dmem_req;
    logic                     pc_stall;
    logic                     if_id_stall;
    logic                     if_id_flush;
    logic                     id_ex_bubble;
    logic                     ex_mem_stall;
    logic                     mem_wb_bubble;
    logic                     mem_timeout_err;
    logic [CNT_WIDTH-1:0]     stall_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
        output ex_valid, ex_is_load, ex_rf_wr, ex_dst, ex_br_taken,
        output mem_valid, mem_is_access, dmem_ack,
        input  dmem_req, pc_stall, if_id_stall, if_id_flush, id_ex_bubble,
        input  ex_mem_stall, mem_wb_bubble, mem_timeout_err, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
        input  ex_valid, ex_is_load, ex_rf_wr, ex_dst, ex_br_taken,
        input  mem_valid, mem_is_access, dmem_ack,
        output dmem_req, pc_stall, if_id_stall, if_id_flush, id_ex_bubble,
        output ex_mem_stall, mem_wb_bubble, mem_timeout_err, stall_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - 5-stage pipeline stall/flush sequencer with dmem wait FSM
//
// Ports:
//   clk  : clock
//   rst  : asynchronous active-high reset
//   bus  : pipeline_hazard_ctrl_if.slave - ID register usage, EX load/branch status,
//          MEM access status and dmem handshake in; stall/bubble/flush controls,
//          dmem_req, sticky timeout flag and saturating stall counter out.
module pipeline_hazard_ctrl #(
    parameter int REG_NUM_WIDTH = 5,
    parameter int MEM_TIMEOUT   = 16,
    parameter int CNT_WIDTH     = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    pipeline_hazard_ctrl_if.slave   bus
);
    localparam int WCW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCW-1:0] TIMEOUT_V = WCW'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WCW-1:0]       wait_cnt_q, wait_cnt_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

    logic [REG_NUM_WIDTH-1:0] id_rs, id_rt, ex_dst;
    logic access, lu, br;

    logic dmem_req, memstall, pc_stall, if_id_stall, if_id_flush;
    logic id_ex_bubble, ex_mem_stall, mem_wb_bubble, mem_timeout_err;

    assign id_rs  = bus.id_rs;
    assign id_rt  = bus.id_rt;
    assign ex_dst = bus.ex_dst;

    assign access = bus.mem_valid & bus.mem_is_access;
    assign br     = bus.ex_valid & bus.ex_br_taken;
    // Register 0 is hard-wired zero, so a load into it never creates a dependency.
    assign lu     = bus.id_valid & bus.ex_valid & bus.ex_is_load & bus.ex_rf_wr &
                    (ex_dst != '0) &
                    ((bus.id_use_rs & (id_rs == ex_dst)) | (bus.id_use_rt & (id_rt == ex_dst)));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        stall_cnt_d = stall_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (access && !bus.dmem_ack) begin
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = WCW'(1);
                end
            end
            ST_MEM_WAIT: begin
                // A vanished access is treated like an ack so the pipeline can't wedge.
                if (bus.dmem_ack || !access) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == TIMEOUT_V) begin
                    state_d = ST_ERROR;
                end else begin
                    wait_cnt_d = wait_cnt_q + WCW'(1);
                end
            end
            ST_ERROR: state_d = ST_ERROR;
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = '0;
            end
        endcase
        if (pc_stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
        end
    end

    // Output logic; everything is gated by rst so outputs drop the instant reset asserts.
    always_comb begin
        dmem_req        = 1'b0;
        memstall        = 1'b0;
        pc_stall        = 1'b0;
        if_id_stall     = 1'b0;
        if_id_flush     = 1'b0;
        id_ex_bubble    = 1'b0;
        ex_mem_stall    = 1'b0;
        mem_wb_bubble   = 1'b0;
        mem_timeout_err = 1'b0;
        if (!rst) begin
            dmem_req        = access && (state_q != ST_ERROR);
            memstall        = dmem_req && !bus.dmem_ack;
            mem_timeout_err = (state_q == ST_ERROR);
            if (memstall || (state_q == ST_ERROR)) begin
                // EX is frozen: branch and load-use get re-evaluated after the stall.
                pc_stall      = 1'b1;
                if_id_stall   = 1'b1;
                ex_mem_stall  = 1'b1;
                mem_wb_bubble = 1'b1;
            end else if (br) begin
                // Consumer in ID is squashed, so a coincident load-use is moot.
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
            end else if (lu) begin
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_bubble = 1'b1;
            end
        end
    end

    assign bus.dmem_req        = dmem_req;
    assign bus.pc_stall        = pc_stall;
    assign bus.if_id_stall     = if_id_stall;
    assign bus.if_id_flush     = if_id_flush;
    assign bus.id_ex_bubble    = id_ex_bubble;
    assign bus.ex_mem_stall    = ex_mem_stall;
    assign bus.mem_wb_bubble   = mem_wb_bubble;
    assign bus.mem_timeout_err = mem_timeout_err;
    assign bus.stall_cnt       = rst ? '0 : stall_cnt_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - scoreboard bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.REG_NUM_WIDTH(5), .CNT_WIDTH(32)) bus();

    pipeline_hazard_ctrl #(
        .REG_NUM_WIDTH(5),
        .MEM_TIMEOUT  (TO),
        .CNT_WIDTH    (32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // ctl = {dmem_req,pc_stall,if_id_stall,if_id_flush,id_ex_bubble,ex_mem_stall,mem_wb_bubble,mem_timeout_err}
    wire [7:0] obs_ctl = {bus.dmem_req, bus.pc_stall, bus.if_id_stall, bus.if_id_flush,
                          bus.id_ex_bubble, bus.ex_mem_stall, bus.mem_wb_bubble, bus.mem_timeout_err};

    typedef struct {
        logic [7:0]  ctl;
        logic [31:0] cnt;
        string       tag;
    } exp_t;
    exp_t exp_q[$];

    // Reference model: 0=RUN 1=MEM_WAIT 2=ERROR
    int          m_state;
    int          m_wait;
    logic [31:0] m_scnt;

    always @(negedge clk) begin
        if (!rst && exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check_eq({e.tag, "_ctl"}, {56'd0, obs_ctl}, {56'd0, e.ctl});
            check_eq({e.tag, "_cnt"}, {32'd0, bus.stall_cnt}, {32'd0, e.cnt});
        end
    end

    // Drives one cycle of stimulus starting just after a rising edge.
    task automatic cyc(input string tag,
                       input logic idv, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt,
                       input logic exv, input logic ld, input logic wr, input logic [4:0] dst,
                       input logic brt, input logic mv, input logic acc, input logic ack);
        logic a, req, ms, lu_h, br_h, err;
        logic pc, ifs, fl, bub, exs, wbb;
        exp_t e;
        bus.id_valid = idv; bus.id_rs = rs; bus.id_rt = rt;
        bus.id_use_rs = urs; bus.id_use_rt = urt;
        bus.ex_valid = exv; bus.ex_is_load = ld; bus.ex_rf_wr = wr; bus.ex_dst = dst;
        bus.ex_br_taken = brt; bus.mem_valid = mv; bus.mem_is_access = acc; bus.dmem_ack = ack;

        a    = mv & acc;
        err  = (m_state == 2);
        req  = a & !err;
        ms   = req & !ack;
        br_h = exv & brt;
        lu_h = idv & exv & ld & wr & (dst != 5'd0) & ((urs & (rs == dst)) | (urt & (rt == dst)));
        {pc, ifs, fl, bub, exs, wbb} = 6'b0;
        if (ms || err) {pc, ifs, exs, wbb} = 4'b1111;
        else if (br_h) {fl, bub} = 2'b11;
        else if (lu_h) {pc, ifs, bub} = 3'b111;
        e.ctl = {req, pc, ifs, fl, bub, exs, wbb, err};
        e.cnt = m_scnt;
        e.tag = tag;
        exp_q.push_back(e);

        @(posedge clk);
        if (pc && m_scnt != 32'hFFFF_FFFF) m_scnt = m_scnt + 1;
        case (m_state)
            0: if (a && !ack) begin m_state = 1; m_wait = 1; end
            1: begin
                if (ack || !a) begin m_state = 0; m_wait = 0; end
                else if (m_wait == TO) m_state = 2;
                else m_wait = m_wait + 1;
            end
            default: m_state = 2;
        endcase
        #1;
    endtask

    task automatic idle(input string tag);
        cyc(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        m_state = 0; m_wait = 0; m_scnt = 0;
        rst = 1'b1;
        // Inputs that would request and stall if not held in reset
        bus.id_valid = 1; bus.id_rs = 5; bus.id_rt = 0; bus.id_use_rs = 1; bus.id_use_rt = 0;
        bus.ex_valid = 1; bus.ex_is_load = 1; bus.ex_rf_wr = 1; bus.ex_dst = 5; bus.ex_br_taken = 1;
        bus.mem_valid = 1; bus.mem_is_access = 1; bus.dmem_ack = 0;
        #2;
        check_eq("rst_ctl", {56'd0, obs_ctl}, 64'd0);
        check_eq("rst_cnt", {32'd0, bus.stall_cnt}, 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        idle("idle0");
        idle("idle1");

        // Load-use: one bubble cycle, then the load has moved on
        cyc("lu", 1, 5, 0, 1, 0, 1, 1, 1, 5, 0, 0, 0, 0);
        check_eq("lu_cnt_after", {32'd0, bus.stall_cnt}, 64'd1);
        cyc("lu_clear", 1, 5, 0, 1, 0, 1, 0, 0, 0, 0, 1, 1, 1);

        // x0 exemption and unused rt
        cyc("x0", 1, 0, 0, 1, 0, 1, 1, 1, 0, 0, 0, 0, 0);
        cyc("rt_unused", 1, 3, 7, 1, 0, 1, 1, 1, 7, 0, 0, 0, 0);
        cyc("rt_used", 1, 3, 7, 0, 1, 1, 1, 1, 7, 0, 0, 0, 0);
        check_eq("x0_cnt", {32'd0, bus.stall_cnt}, 64'd2);

        // Branch beats load-use
        cyc("br_lu", 1, 5, 0, 1, 0, 1, 1, 1, 5, 1, 0, 0, 0);
        check_eq("br_lu_cnt", {32'd0, bus.stall_cnt}, 64'd2);

        // Three-cycle memory wait with a concurrent branch held off by the stall
        cyc("mw0", 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 1, 0);
        cyc("mw1", 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 1, 0);
        cyc("mw2", 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 1, 0);
        cyc("mw_ack", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
        check_eq("mw_cnt", {32'd0, bus.stall_cnt}, 64'd5);
        cyc("mw_br_after", 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0);

        // Zero-wait access
        cyc("zw", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
        cyc("zw_next", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
        check_eq("zw_cnt", {32'd0, bus.stall_cnt}, 64'd5);

        // Access vanishing mid-wait returns to RUN
        cyc("drop0", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        cyc("drop1", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc("drop2", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
        check_eq("drop_cnt", {32'd0, bus.stall_cnt}, 64'd6);

        // Timeout: request cycle + TO wait cycles, then ERROR
        for (int i = 0; i < TO + 4; i++) begin
            cyc($sformatf("to%0d", i), 1, 5, 0, 1, 0, 1, 1, 1, 5, 1, 1, 1, 0);
        end
        check_eq("to_err", {63'd0, bus.mem_timeout_err}, 64'd1);
        check_eq("to_req", {63'd0, bus.dmem_req}, 64'd0);
        check_eq("to_frozen", {63'd0, bus.pc_stall}, 64'd1);
        check_eq("to_cnt", {32'd0, bus.stall_cnt}, 64'd6 + 64'(TO + 4));
        // Late ack does not leave ERROR
        cyc("to_ack", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);

        // Asynchronous reset mid-cycle
        bus.dmem_ack = 0;
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_ctl", {56'd0, obs_ctl}, 64'd0);
        check_eq("arst_cnt", {32'd0, bus.stall_cnt}, 64'd0);
        m_state = 0; m_wait = 0; m_scnt = 0;
        @(posedge clk); #1;
        rst = 1'b0;

        // Normal operation after reset
        cyc("post_lu", 1, 9, 9, 0, 1, 1, 1, 1, 9, 0, 0, 0, 0);
        cyc("post_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_eq("post_cnt", {32'd0, bus.stall_cnt}, 64'd1);

        @(negedge clk); #1;
        check_eq("q_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline (IF, ID, EX, MEM, WB).
- Consumes decoded register usage from ID, load and branch status from EX, and data-memory handshake status from MEM.
- Drives per-stage stall, bubble and flush controls.
- Owns the multi-cycle data-memory wait FSM, its timeout watchdog and a stall performance counter.

Parameters:
REG_NUM_WIDTH, 5, register-number width.
MEM_TIMEOUT, 16, MEM_WAIT cycles before a timeout error (≥2).
CNT_WIDTH, 32, stall counter width.

Ports:
clk  input  1  clock
rst  input  1  reset
id_valid  input  1  valid instruction in ID
id_rs  input  REG_NUM_WIDTH  ID source rs
id_rt  input  REG_NUM_WIDTH  ID source rt
id_use_rs  input  1  ID instruction reads rs
id_use_rt  input  1  ID instruction reads rt
ex_valid  input  1  valid instruction in EX
ex_is_load  input  1  EX instruction is a load
ex_rf_wr  input  1  EX instruction writes the register file
ex_dst  input  REG_NUM_WIDTH  EX destination register
ex_br_taken  input  1  EX branch resolved taken
mem_valid  input  1  valid instruction in MEM
mem_is_access  input  1  MEM instruction is a load or store
dmem_ack  input  1  data memory completes the current access
dmem_req  output  1  data memory access request
pc_stall  output  1  hold PC
if_id_stall  output  1  hold IF/ID register
if_id_flush  output  1  clear IF/ID register to NOP
id_ex_bubble  output  1  load NOP into ID/EX
ex_mem_stall  output  1  hold ID/EX and EX/MEM registers
mem_wb_bubble  output  1  load NOP into MEM/WB
mem_timeout_err  output  1  sticky data-memory timeout flag
stall_cnt  output  CNT_WIDTH  saturating count of pc_stall cycles

Behaviour:
- clk is the single clock. rst is asynchronous and active-high.
- While rst=1: state=RUN, wait counter=0, stall_cnt=0, mem_timeout_err=0, and every output is 0.
- FSM states: RUN, MEM_WAIT, ERROR.
- Signal definitions:
  - access = mem_valid & mem_is_access.
  - memstall = dmem_req & ~dmem_ack.
  - lu (load-use) = id_valid & ex_valid & ex_is_load & ex_rf_wr & (ex_dst≠0) & ((id_use_rs & id_rs==ex_dst) | (id_use_rt & id_rt==ex_dst)).
  - br = ex_valid & ex_br_taken.
- dmem_req = access, in RUN and MEM_WAIT only. dmem_req=0 in ERROR.
- All control outputs are combinational, evaluated in priority order:
  1. memstall, or state ERROR: pc_stall=1, if_id_stall=1, ex_mem_stall=1, mem_wb_bubble=1. if_id_flush=0 and id_ex_bubble=0. lu and br are ignored; EX is frozen, so they are re-evaluated once the stall clears.
  2. br: if_id_flush=1, id_ex_bubble=1, pc_stall=0 (PC takes the branch target). lu is ignored because the consumer is squashed.
  3. lu: pc_stall=1, if_id_stall=1, id_ex_bubble=1. Exactly one bubble cycle; the load reaches MEM next cycle and the hazard clears.
  4. Otherwise all control outputs are 0.
- Transitions:
  - RUN→MEM_WAIT when access & ~dmem_ack. Wait counter←1.
  - RUN stays in RUN when ack arrives in the request cycle: zero-wait access, no stall.
  - MEM_WAIT→RUN on dmem_ack. Stall outputs drop in the ack cycle, so the pipeline advances on that edge. Wait counter←0.
  - MEM_WAIT, no ack: wait counter++. When the counter reaches MEM_TIMEOUT (ack absent that cycle), go to ERROR.
  - ERROR→ERROR until rst. mem_timeout_err=1 in ERROR. The pipeline stays frozen.
  - If access drops during MEM_WAIT (illegal), treat it as an ack: →RUN.
- stall_cnt increments on each rising edge where pc_stall=1. It saturates at all-ones.
- Reset asserted mid-MEM_WAIT aborts immediately. dmem_req falls asynchronously.

Test Plan:
- Load-use hazard: ex: load, ex_dst=5. id: id_rs=5, id_use_rs=1. Required: pc_stall=if_id_stall=id_ex_bubble=1 for exactly 1 cycle; stall_cnt 0→1.
- x0 exemption: same as above with ex_dst=0, id_rs=0. Required: no stall. Separately, id_use_rt=0 with id_rt==ex_dst. Required: no stall.
- Branch plus load-use in the same cycle: br=1 and lu=1. Required: if_id_flush=1, id_ex_bubble=1, pc_stall=0; stall_cnt unchanged.
- Three-cycle memory wait: access, dmem_ack arrives 3 cycles later. Required: state MEM_WAIT for 3 cycles; pc_stall/ex_mem_stall/mem_wb_bubble high for 3 cycles and low in the ack cycle; dmem_req high for all 4 cycles; stall_cnt=3. Also, a concurrent br during the wait produces no flush until after the ack.
- Zero-wait access: access with dmem_ack in the same cycle. Required: no stall, state remains RUN.
- Timeout and reset: access, never ack, MEM_TIMEOUT=16. Required: ERROR after 16 wait cycles, mem_timeout_err=1, dmem_req=0, pipeline frozen. Then asserting rst asynchronously (mid-cycle) clears all outputs and stall_cnt to 0 immediately.
